// File: rtl/lfsr_decrypt6.sv
// rtl/lfsr_decrypt6.sv - 6-bit LFSR stream decryptor with preamble-based seed/tap recovery
module lfsr_decrypt6 #(
    parameter int PRE_LEN = 7
) (
    input  logic       clk,
    input  logic       init,
    input  logic       req,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic [5:0] taps,
    output logic [2:0] tap_idx,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_TRAIN,
        S_LOCK,
        S_DECODE,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t     state, state_nxt;

    logic [5:0] cand [0:5];
    logic [5:0] alive;
    logic [5:0] lfsr;
    logic [3:0] cnt;
    logic [2:0] lowest;
    logic       accept;
    logic       dec_ready;

    // Only the low six bits carry cipher text; the top two are don't-care.
    logic       unused_hi;
    assign unused_hi = ^in_data[7:6];

    function automatic logic [5:0] pattern(input logic [2:0] k);
        case (k)
            3'd0:    return 6'h21;
            3'd1:    return 6'h2D;
            3'd2:    return 6'h30;
            3'd3:    return 6'h33;
            3'd4:    return 6'h36;
            default: return 6'h39;
        endcase
    endfunction

    function automatic logic [5:0] step(input logic [5:0] s, input logic [5:0] t);
        return {s[4:0], ^(s & t)};
    endfunction

    assign dec_ready = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    // Lowest-numbered surviving candidate wins when several patterns fit the preamble.
    always_comb begin
        lowest = 3'd0;
        for (int k = 5; k >= 0; k--) begin
            if (alive[k]) lowest = 3'(k);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (init) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode and per-state handshake/status outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) state_nxt = S_SEED;
            end
            S_SEED: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data[5:0] == 6'd0 || in_last) state_nxt = S_ERR;
                    else                                 state_nxt = S_TRAIN;
                end
            end
            S_TRAIN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_last)                         state_nxt = S_ERR;
                    else if (cnt == 4'(PRE_LEN - 1))     state_nxt = S_LOCK;
                end
            end
            S_LOCK: begin
                if (alive == 6'd0) state_nxt = S_ERR;
                else               state_nxt = S_DECODE;
            end
            S_DECODE: begin
                in_ready = dec_ready;
                if (in_valid && dec_ready && in_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_valid && out_ready) state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (req) state_nxt = S_SEED;
            end
            S_ERR: begin
                err = 1'b1;
                if (req) state_nxt = S_SEED;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Candidate tracking during the preamble, pattern lock, and the decode output register.
    always_ff @(posedge clk) begin
        if (init) begin
            for (int k = 0; k < 6; k++) cand[k] <= 6'd0;
            alive     <= 6'b111111;
            lfsr      <= 6'd0;
            cnt       <= 4'd0;
            taps      <= 6'd0;
            tap_idx   <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (req) alive <= 6'b111111;
                end
                S_SEED: begin
                    if (in_valid) begin
                        for (int k = 0; k < 6; k++) cand[k] <= in_data[5:0];
                        alive <= 6'b111111;
                        cnt   <= 4'd1;
                    end
                end
                S_TRAIN: begin
                    if (in_valid) begin
                        for (int k = 0; k < 6; k++) begin
                            cand[k] <= step(cand[k], pattern(3'(k)));
                            if (step(cand[k], pattern(3'(k))) != in_data[5:0])
                                alive[k] <= 1'b0;
                        end
                        cnt <= cnt + 4'd1;
                    end
                end
                S_LOCK: begin
                    if (alive != 6'd0) begin
                        tap_idx <= lowest;
                        taps    <= pattern(lowest);
                        lfsr    <= step(cand[lowest], pattern(lowest));
                    end
                end
                S_DECODE, S_DRAIN: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                    if (state == S_DECODE && accept) begin
                        out_data  <= {2'b00, in_data[5:0] ^ lfsr} + 8'h20;
                        out_last  <= in_last;
                        out_valid <= 1'b1;
                        lfsr      <= step(lfsr, taps);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
